// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues IMEM reads, buffers the returned words in a queue and hands inst/pc pairs to decode.
// Latency: a returned word appears on INST one cycle after its RVALID edge; 1-cycle memory gives one instruction per cycle.
// Backpressure: DECODE_READY=0 holds the head; queued plus outstanding reads are capped at DEPTH, so IMEM_REQ drops instead of overflowing.

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   core_clk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (level != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_rdy & pop_vld;
  assign do_push = push_vld & ((level != (AW+1)'(DEPTH)) | do_pop);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge core_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        FETCH_EN,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        DECODE_READY
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } q_ent_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  cnt_t        outstanding;
  cnt_t        outstanding_nxt;
  cnt_t        drop_cnt;
  cnt_t        drop_nxt;
  cnt_t        q_level;
  logic        req;
  logic        xfer;
  logic        rsp;
  logic        rsp_drop;
  logic        push;
  logic        head_vld;
  logic [31:0] rsp_pc;
  q_ent_t      push_ent;
  q_ent_t      head_ent;

  // Live reads issued since the last redirect are contiguous and end just below fetch_pc.
  assign rsp_pc   = fetch_pc - 32'(outstanding - drop_cnt);
  assign push_ent = '{inst: IMEM_RDATA, pc: rsp_pc};

  always_comb begin
    req             = 1'b0;
    rsp             = 1'b0;
    rsp_drop        = 1'b0;
    push            = 1'b0;
    xfer            = 1'b0;
    outstanding_nxt = outstanding;
    drop_nxt        = drop_cnt;
    state_nxt       = state;

    req  = FETCH_EN && (state != BOOT) &&
           (({1'b0, q_level} + {1'b0, outstanding}) < {1'b0, DEPTH_C});
    xfer = req && IMEM_READY;

    // A response with nothing outstanding is a protocol error and is ignored.
    rsp      = IMEM_RVALID && (outstanding != '0);
    rsp_drop = rsp && (REDIRECT || (drop_cnt != '0));
    push     = rsp && !rsp_drop;

    outstanding_nxt = outstanding + cnt_t'(xfer) - cnt_t'(rsp);

    if (REDIRECT) begin
      drop_nxt = outstanding_nxt;
    end else if (rsp && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - cnt_t'(1);
    end

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      SQUASH:  state_nxt = (drop_nxt == '0) ? RUN : SQUASH;
      default: state_nxt = RUN;
    endcase
    if (REDIRECT) state_nxt = (drop_nxt != '0) ? SQUASH : RUN;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= BOOT;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      if (REDIRECT)  fetch_pc <= REDIRECT_PC;
      else if (xfer) fetch_pc <= fetch_pc + 32'd1;
    end
  end

  fifo #(
    .WIDTH ($bits(q_ent_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .core_clk (CLK),
    .arst_n   (RSTN),
    .flush    (REDIRECT),
    .push_vld (push),
    .push_dat (push_ent),
    .pop_rdy  (DECODE_READY),
    .pop_vld  (head_vld),
    .pop_dat  (head_ent),
    .level    (q_level)
  );

  assign IMEM_REQ   = req;
  assign IMEM_ADDR  = fetch_pc;
  assign INST_VALID = head_vld;
  assign INST       = head_vld ? head_ent.inst : NOP_INST;
  assign INST_PC    = head_vld ? head_ent.pc : 32'd0;

  a_bounds: assert property (@(posedge CLK) disable iff (!RSTN)
    (outstanding <= DEPTH_C) && (drop_cnt <= DEPTH_C) &&
    (q_level <= DEPTH_C) && (drop_cnt <= outstanding));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model plus a scoreboard of expected inst/pc pairs.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK;
  logic        RSTN;
  logic        FETCH_EN;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        DECODE_READY;

  fetch_unit dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .FETCH_EN     (FETCH_EN),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_READY   (IMEM_READY),
    .IMEM_RVALID  (IMEM_RVALID),
    .IMEM_RDATA   (IMEM_RDATA),
    .INST_VALID   (INST_VALID),
    .INST         (INST),
    .INST_PC      (INST_PC),
    .DECODE_READY (DECODE_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  typedef struct { int due; logic [31:0] dat; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  logic [31:0] data_xor = 32'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] last_pc = 32'd0;
  logic        s_vld = 1'b0;
  logic        s_req = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ data_xor;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", {31'd0, IMEM_REQ}, 32'd0);
    check("rst_imem_addr", IMEM_ADDR, 32'd0);
    check("rst_inst_valid", {31'd0, INST_VALID}, 32'd0);
    check("rst_inst", INST, NOP);
    check("rst_inst_pc", INST_PC, 32'd0);
  endtask

  // One clock: memory drives its response at the falling edge, outputs are sampled just after.
  task automatic step();
    logic xfer;
    logic pop;
    @(negedge CLK);
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = mem_q[0].dat;
      void'(mem_q.pop_front());
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = 32'hDEADBEEF;
    end
    #1;
    if (prev_stall && FETCH_EN && RSTN) begin
      check("stall_req_hold", {31'd0, IMEM_REQ}, 32'd1);
      check("stall_addr_hold", IMEM_ADDR, prev_addr);
    end
    if (!INST_VALID) check("nop_when_invalid", INST, NOP);
    xfer = IMEM_REQ & IMEM_READY;
    pop  = INST_VALID & DECODE_READY;
    if (pop) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_inst", INST, exp_q[0].inst);
        check("sb_pc", INST_PC, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      pops++;
      last_pc = INST_PC;
    end
    if (REDIRECT && RSTN) exp_q.delete();
    if (xfer) begin
      check("imem_addr_seq", IMEM_ADDR, exp_addr);
      mem_q.push_back('{due: cyc + lat, dat: mem_word(IMEM_ADDR)});
      if (!REDIRECT) exp_q.push_back('{inst: mem_word(exp_addr), pc: exp_addr});
      exp_addr = exp_addr + 32'd1;
    end
    if (REDIRECT && RSTN) exp_addr = REDIRECT_PC;
    s_vld      = INST_VALID;
    s_req      = IMEM_REQ;
    prev_stall = RSTN & IMEM_REQ & ~IMEM_READY & ~REDIRECT;
    prev_addr  = IMEM_ADDR;
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step();
    check("drain_empty", exp_q.size() + mem_q.size(), 32'd0);
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] pc);
    int p0;
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) step();
    check({tag, "_seen"}, {31'd0, pops != p0}, 32'd1);
    check(tag, last_pc, pc);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    REDIRECT    = 1'b1;
    REDIRECT_PC = pc;
    step();
    REDIRECT    = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; FETCH_EN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
    IMEM_READY = 1'b1; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'd0; DECODE_READY = 1'b1;
    #3;
    check_reset_outputs();
    run(2);

    // Fill with 1-cycle memory, then one instruction per cycle.
    RSTN = 1'b1; FETCH_EN = 1'b1;
    step();
    check("boot_no_req", {31'd0, s_req}, 32'd0);
    run(4);
    for (int i = 0; i < 10; i++) begin
      step();
      check("steady_valid", {31'd0, s_vld}, 32'd1);
    end

    // Decoder stall: queued plus outstanding saturates at DEPTH.
    DECODE_READY = 1'b0;
    run(10);
    check("cap_req_low", {31'd0, s_req}, 32'd0);
    check("cap_inflight", exp_q.size(), 32'd4);
    DECODE_READY = 1'b1;
    run(12);
    FETCH_EN = 1'b0;
    drain();
    data_xor = 32'hA5A50000;

    // Memory not ready for 5 cycles.
    FETCH_EN = 1'b1;
    run(3);
    IMEM_READY = 1'b0;
    run(5);
    IMEM_READY = 1'b1;
    run(6);

    // Redirect coincident with a response and a request transfer.
    run(2);
    redirect_to(32'd10);
    check("coinc_xfer", {31'd0, s_req}, 32'd1);
    step();
    check("flush_valid_low", {31'd0, s_vld}, 32'd0);
    wait_pop("coinc_first_pc", 32'd10);
    wait_pop("coinc_second_pc", 32'd11);

    // 3-cycle memory, redirect with exactly two reads in flight.
    FETCH_EN = 1'b0;
    drain();
    lat = 3;
    FETCH_EN = 1'b1;
    run(2);
    FETCH_EN = 1'b0;
    redirect_to(32'd36);
    FETCH_EN = 1'b1;
    wait_pop("squash_first_pc", 32'd36);
    wait_pop("squash_second_pc", 32'd37);

    // Address wrap across 32'hFFFFFFFF.
    run(4);
    redirect_to(32'hFFFFFFFE);
    wait_pop("wrap_pc0", 32'hFFFFFFFE);
    wait_pop("wrap_pc1", 32'hFFFFFFFF);
    wait_pop("wrap_pc2", 32'h00000000);
    wait_pop("wrap_pc3", 32'h00000001);

    // Back-to-back redirects: the second lands while squashing.
    run(3);
    redirect_to(32'd100);
    redirect_to(32'd200);
    wait_pop("double_redirect_pc", 32'd200);
    wait_pop("double_redirect_pc_next", 32'd201);

    // Reset mid-stream with two reads in flight; their late responses must be ignored.
    FETCH_EN = 1'b0;
    drain();
    FETCH_EN = 1'b1;
    run(2);
    RSTN = 1'b0;
    exp_q.delete();
    exp_addr   = 32'd0;
    prev_stall = 1'b0;
    #1;
    check_reset_outputs();
    step();
    RSTN = 1'b1;
    step();
    check("reboot_no_req", {31'd0, s_req}, 32'd0);
    wait_pop("reboot_first_pc", 32'd0);
    wait_pop("reboot_second_pc", 32'd1);
    FETCH_EN = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
